ov_capture: RTL

Camera-side capture stage on the PCLK domain, fed directly by the OV7670/OV9655 parallel bus (PCLK, VSYNC, HREF, DATA). It pairs the two bytes of each pixel, decodes the RGB444/RGB565/RGB555 formats, and emits one pixel per valid cycle with frame and line markers and X/Y coordinates. It also checks frame geometry. Downstream consumers, such as the CDC FIFO or frame writer, see a clean single-cycle pixel stream.

---
 rtl/ov_capture.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ov_capture.sv
`default_nettype none
// ============================================================================
//  Module      : ov_capture
//  Description : OV7670/OV9655 parallel-bus capture. Pairs bytes into pixels,
//                decodes RGB444/565/555 and checks frame geometry.
//  Revision    : 1.0  initial release
// ============================================================================
module ov_capture #(
   parameter int HSIZE = 640,
   parameter int VSIZE = 480
) (
   input  logic        PCLK,
   input  logic        RESETN,
   input  logic        ENABLE,
   input  logic        VSYNC,
   input  logic        HREF,
   input  logic [7:0]  DATA,
   input  logic [31:0] PIXEL_FORMAT,
   output logic        PIX_VALID,
   output logic [15:0] PIX_RAW,
   output logic [7:0]  PIX_R,
   output logic [7:0]  PIX_G,
   output logic [7:0]  PIX_B,
   output logic [15:0] PIX_X,
   output logic [15:0] PIX_Y,
   output logic        SOF,
   output logic        EOL,
   output logic        FRAME_DONE,
   output logic        FRAME_ERR,
   output logic        BUSY
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SYNC   = 2'd1,
      ST_VBLANK = 2'd2,
      ST_ACTIVE = 2'd3
   } state_t;

   localparam logic [15:0] C_HSIZE = 16'(HSIZE);
   localparam logic [15:0] C_VSIZE = 16'(VSIZE);
   localparam logic [15:0] C_SAT   = 16'hFFFF;

   state_t      r_state;
   logic        r_vsync_d;
   logic        r_href_d;
   logic        r_byte_pos;
   logic [7:0]  r_byte0;
   logic [15:0] r_x_cnt;
   logic [15:0] r_y_cnt;
   logic        r_err;

   logic        w_active;
   logic        w_vsync_rise;
   logic        w_href_fall;
   logic        w_line_err;
   logic [15:0] w_y_next;
   logic [7:0]  w_r;
   logic [7:0]  w_g;
   logic [7:0]  w_b;

   assign w_active     = (r_state == ST_ACTIVE);
   assign w_vsync_rise = VSYNC & ~r_vsync_d;
   assign w_href_fall  = ~HREF & r_href_d;
   assign w_line_err   = w_active & w_href_fall & ((r_x_cnt != C_HSIZE) | r_byte_pos);
   assign w_y_next     = (w_href_fall && (r_y_cnt != C_SAT)) ? r_y_cnt + 16'd1 : r_y_cnt;
   assign BUSY         = (r_state != ST_IDLE);

   // byte1 is decoded straight off the bus on the edge that completes the pixel
   always_comb begin
      w_r = 8'd0;
      w_g = 8'd0;
      w_b = 8'd0;
      case (PIXEL_FORMAT)
         32'd0: begin
            w_r = {4'd0, r_byte0[3:0]};
            w_g = {4'd0, DATA[7:4]};
            w_b = {4'd0, DATA[3:0]};
         end
         32'd1: begin
            w_r = {3'd0, r_byte0[7:3]};
            w_g = {2'd0, r_byte0[2:0], DATA[7:5]};
            w_b = {3'd0, DATA[4:0]};
         end
         32'd2: begin
            w_r = {3'd0, r_byte0[6:2]};
            w_g = {3'd0, r_byte0[1:0], DATA[7:5]};
            w_b = {3'd0, DATA[4:0]};
         end
         default: ;
      endcase
   end

   always_ff @(posedge PCLK or negedge RESETN) begin
      if (!RESETN) begin
         r_state    <= ST_IDLE;
         r_vsync_d  <= 1'b0;
         r_href_d   <= 1'b0;
         r_byte_pos <= 1'b0;
         r_byte0    <= 8'd0;
         r_x_cnt    <= 16'd0;
         r_y_cnt    <= 16'd0;
         r_err      <= 1'b0;
         PIX_VALID  <= 1'b0;
         PIX_RAW    <= 16'd0;
         PIX_R      <= 8'd0;
         PIX_G      <= 8'd0;
         PIX_B      <= 8'd0;
         PIX_X      <= 16'd0;
         PIX_Y      <= 16'd0;
         SOF        <= 1'b0;
         EOL        <= 1'b0;
         FRAME_DONE <= 1'b0;
         FRAME_ERR  <= 1'b0;
      end else begin
         r_vsync_d  <= VSYNC;
         r_href_d   <= HREF;
         PIX_VALID  <= 1'b0;
         SOF        <= 1'b0;
         EOL        <= 1'b0;
         FRAME_DONE <= 1'b0;
         FRAME_ERR  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (ENABLE) r_state <= ST_SYNC;
            end
            ST_SYNC: begin
               if (!ENABLE)    r_state <= ST_IDLE;
               else if (VSYNC) r_state <= ST_VBLANK;
            end
            ST_VBLANK: begin
               if (!ENABLE) begin
                  r_state <= ST_IDLE;
               end else if (!VSYNC) begin
                  r_state    <= ST_ACTIVE;
                  r_byte_pos <= 1'b0;
                  r_x_cnt    <= 16'd0;
                  r_y_cnt    <= 16'd0;
                  r_err      <= 1'b0;
               end
            end
            ST_ACTIVE: begin
               if (HREF) begin
                  r_byte_pos <= ~r_byte_pos;
                  if (!r_byte_pos) begin
                     r_byte0 <= DATA;
                  end else begin
                     // out-of-window pixels still advance x_cnt for the geometry check
                     if ((r_x_cnt < C_HSIZE) && (r_y_cnt < C_VSIZE)) begin
                        PIX_VALID <= 1'b1;
                        PIX_RAW   <= {r_byte0, DATA};
                        PIX_R     <= w_r;
                        PIX_G     <= w_g;
                        PIX_B     <= w_b;
                        PIX_X     <= r_x_cnt;
                        PIX_Y     <= r_y_cnt;
                        SOF       <= (r_x_cnt == 16'd0) && (r_y_cnt == 16'd0);
                        EOL       <= (r_x_cnt == C_HSIZE - 16'd1);
                     end
                     if (r_x_cnt != C_SAT) r_x_cnt <= r_x_cnt + 16'd1;
                  end
               end else begin
                  r_byte_pos <= 1'b0;
               end
               if (w_href_fall) begin
                  r_x_cnt <= 16'd0;
                  r_y_cnt <= w_y_next;
                  if (w_line_err) r_err <= 1'b1;
               end
               if (w_vsync_rise) begin
                  FRAME_DONE <= 1'b1;
                  FRAME_ERR  <= r_err | w_line_err | (w_y_next != C_VSIZE);
                  r_state    <= ENABLE ? ST_VBLANK : ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
